// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage between the PC register and the ID stage. It
//   issues one request at a time on an SRAM-like instruction bus, captures
//   the returned word and delivers {pc, inst} to ID through an output
//   register backed by a one-entry hold buffer. It raises fetch_stall_req to
//   CTRL while a fetch is pending and handles CP0 flushes, including
//   cancelling a response that is already in flight.
//
// Ports
//   cpu_clk_75M, cpu_rst_n   clock, asynchronous active-low reset
//   pc, ce                   fetch address / enable from the PC stage
//   stall[5:0]               CTRL stall vector, stall[1] holds IF/ID
//   cp0_branch_flag          CP0 redirect, flushes this stage
//   fetch_stall_req          asks CTRL to hold PC while a fetch is pending
//   inst_req, inst_addr      request valid / address to instruction memory
//   inst_addr_ok             request accepted this cycle
//   inst_data_ok, inst_rdata read data valid / read data
//   id_valid, id_pc, id_inst delivered instruction to ID
//   id_excp_adel             misaligned-fetch flag (FETCH_ADDR_CHECK_EN only)
//
// Build option
//   FETCH_ADDR_CHECK_EN: misaligned pc raises id_excp_adel instead of fetching.
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        cpu_clk_75M,
    input  logic        cpu_rst_n,
    input  logic [31:0] pc,
    input  logic        ce,
    input  logic [5:0]  stall,
    input  logic        cp0_branch_flag,
    output logic        fetch_stall_req,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
`ifdef FETCH_ADDR_CHECK_EN
    ,
    output logic        id_excp_adel
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic        cancel_q, cancel_d;
    logic        issue;
    logic        accept;
    logic        word_ok;
    logic        new_vld;
    logic [31:0] new_pc;
    logic [31:0] new_inst;
    logic [31:0] req_pc;
    logic        hold_full;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    logic        flush;
    logic        stall_id;
    logic        unused_stall_bits;

`ifdef FETCH_ADDR_CHECK_EN
    logic        adel_fault;
    logic        hold_adel;
`endif

    assign flush             = cp0_branch_flag;
    assign stall_id          = stall[1];
    assign unused_stall_bits = ^{stall[5:2], stall[0]};

    assign fetch_stall_req = (state_q != S_IDLE) | hold_full |
                             ((state_q == S_IDLE) & ce & ~flush);

    // ---------------- FSM ----------------
    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q  <= S_IDLE;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        issue    = 1'b0;
        accept   = 1'b0;
        word_ok  = 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
        adel_fault = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (ce && !flush && !hold_full) begin
`ifdef FETCH_ADDR_CHECK_EN
                    if (pc[1:0] != 2'b00) begin
                        adel_fault = 1'b1;
                    end else begin
                        issue   = 1'b1;
                        state_d = S_REQ;
                    end
`else
                    issue   = 1'b1;
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (inst_addr_ok) begin
                    // An accepted request must still be drained, so a flush
                    // here turns into a pending cancel rather than a drop.
                    accept   = 1'b1;
                    state_d  = S_WAIT;
                    cancel_d = flush;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    state_d  = S_IDLE;
                    cancel_d = 1'b0;
                    word_ok  = !cancel_q && !flush;
                end else if (flush) begin
                    cancel_d = 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                cancel_d = 1'b0;
            end
        endcase
    end

    // ---------------- word to deliver this cycle ----------------
    always_comb begin
        new_vld  = word_ok;
        new_pc   = req_pc;
        new_inst = inst_rdata;
`ifdef FETCH_ADDR_CHECK_EN
        if (adel_fault) begin
            new_vld  = 1'b1;
            new_pc   = pc;
            new_inst = NOP_INST;
        end
`endif
    end

    // ---------------- request and delivery registers ----------------
    // A new word and a full hold buffer never coincide: the buffer only fills
    // when the single outstanding request retires, and IDLE will not issue
    // while it is full.
    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            inst_req  <= 1'b0;
            inst_addr <= '0;
            req_pc    <= '0;
            hold_full <= 1'b0;
            hold_pc   <= '0;
            hold_inst <= NOP_INST;
            id_valid  <= 1'b0;
            id_pc     <= RESET_PC;
            id_inst   <= NOP_INST;
`ifdef FETCH_ADDR_CHECK_EN
            hold_adel    <= 1'b0;
            id_excp_adel <= 1'b0;
`endif
        end else begin
            inst_req <= (state_d == S_REQ);
            if (issue) begin
                inst_addr <= pc;
            end
            if (accept) begin
                req_pc <= inst_addr;
            end

            if (flush) begin
                id_valid  <= 1'b0;
                id_inst   <= NOP_INST;
                hold_full <= 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
                id_excp_adel <= 1'b0;
`endif
            end else if (stall_id) begin
                if (new_vld) begin
                    hold_full <= 1'b1;
                    hold_pc   <= new_pc;
                    hold_inst <= new_inst;
`ifdef FETCH_ADDR_CHECK_EN
                    hold_adel <= adel_fault;
`endif
                end
            end else if (hold_full) begin
                hold_full <= 1'b0;
                id_valid  <= 1'b1;
                id_pc     <= hold_pc;
                id_inst   <= hold_inst;
`ifdef FETCH_ADDR_CHECK_EN
                id_excp_adel <= hold_adel;
`endif
            end else if (new_vld) begin
                id_valid <= 1'b1;
                id_pc    <= new_pc;
                id_inst  <= new_inst;
`ifdef FETCH_ADDR_CHECK_EN
                id_excp_adel <= adel_fault;
`endif
            end else begin
                id_valid <= 1'b0;
                id_inst  <= NOP_INST;
`ifdef FETCH_ADDR_CHECK_EN
                id_excp_adel <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage between the PC register and the ID stage.
- Takes the current pc/ce, issues one request at a time on an SRAM-like handshake instruction-memory bus, and captures the returned word.
- Delivers {pc, inst} to ID through an output register plus a one-entry hold buffer.
- Raises a stall request to CTRL while a fetch is outstanding and handles CP0 (exception/eret) flushes, including cancelling in-flight responses.

Parameters:
- NOP_INST, 32'h0000_0000, instruction word presented to ID when the stage output is invalid or flushed.
- RESET_PC, 32'hBFC0_0000, value of id_pc after reset.

Ports:
- cpu_clk_75M  in  1  stage clock.
- cpu_rst_n  in  1  asynchronous active-low reset.
- pc  in  32  fetch address from the PC stage.
- ce  in  1  PC chip enable; no fetch is issued while 0.
- stall  in  6  CTRL stall vector; stall[1]=1 holds the IF/ID output.
- cp0_branch_flag  in  1  CP0 redirect; flushes this stage.
- fetch_stall_req  out  1  to CTRL; asks to hold PC (stall[0]) while a fetch is pending.
- inst_req  out  1  instruction-memory request valid.
- inst_addr  out  32  request address.
- inst_addr_ok  in  1  memory accepted the request this cycle.
- inst_data_ok  in  1  read data valid this cycle.
- inst_rdata  in  32  read data.
- id_valid  out  1  id_pc/id_inst hold a real instruction.
- id_pc  out  32  PC of the delivered instruction.
- id_inst  out  32  delivered instruction.

Behaviour:
- Reset (async, cpu_rst_n=0):
  - state=IDLE; inst_req=0; inst_addr=0; id_valid=0; id_pc=RESET_PC; id_inst=NOP_INST; hold buffer empty; cancel=0.
- FSM states:
  - IDLE: if ce=1, no flush, and hold buffer empty, drive inst_req=1, inst_addr=pc (registered; goes to REQ).
  - REQ: keep inst_req/inst_addr stable until inst_addr_ok=1, then latch req_pc=inst_addr, drop inst_req and go to WAIT.
  - WAIT: on inst_data_ok=1:
    - if cancel=1, discard the word, clear cancel, go to IDLE;
    - else if stall[1]=0, load id regs {1, req_pc, inst_rdata} and go to IDLE;
    - else write the hold buffer and go to IDLE.
- Only one outstanding request. inst_data_ok outside WAIT is ignored.
- Hold buffer drain: when the buffer is full and stall[1]=0, move it into the id regs and mark it empty in the same cycle.
- id regs with stall[1]=0 and no new word: id_valid<=0 and id_inst<=NOP_INST, so a bubble is inserted.
- fetch_stall_req = (state!=IDLE) | hold_full | (state==IDLE & ce & ~flush). It is combinational, so PC holds until the word is accepted.
- PC advance: pc advances only when CTRL deasserts stall[0]. The stage issues a fetch for pc exactly once per accepted word.
- Flush (cp0_branch_flag=1), all in the same cycle:
  - id_valid<=0, id_inst<=NOP_INST, hold buffer emptied.
  - In REQ: if inst_addr_ok is also 1 this cycle, go to WAIT with cancel=1; else drop inst_req and go to IDLE.
  - In WAIT: set cancel=1 (or, if inst_data_ok is also 1 this cycle, discard the word and go to IDLE).
  - Flush has priority over stall[1].
- ce=0: no new requests. Any outstanding request still completes through the handshake, and its data is delivered normally.
- Reset mid-transaction: all state is cleared immediately. Memory responses after reset release are ignored until a new request is issued.
- Addresses are passed unmodified (no translation). Width is 32 bits throughout.

Optional Feature:
- Macro: FETCH_ADDR_CHECK_EN.
- Defined:
  - in IDLE, if pc[1:0]!=2'b00, no bus request is made;
  - the stage delivers {id_valid=1, id_pc=pc, id_inst=NOP_INST} with a 1-bit output port id_excp_adel=1 (exception raised downstream);
  - id_excp_adel is 0 otherwise, reset 0, cleared by flush.
- Undefined: port id_excp_adel absent; pc[1:0] ignored and passed to inst_addr as is.

Test Plan:
- Reset release with ce=1, pc=BFC00000, memory giving addr_ok same cycle and data_ok next cycle with 3C080001 -> one inst_req at BFC00000; id_valid=1, id_pc=BFC00000, id_inst=3C080001 one cycle after data_ok; fetch_stall_req low afterwards.
- Memory with 3-cycle addr_ok delay -> inst_req/inst_addr stable throughout; fetch_stall_req=1 until data returns; exactly one request.
- stall[1]=1 when data 24020005 for pc BFC00004 arrives -> hold buffer full, id regs unchanged, no new inst_req; stall[1]=0 next cycle -> id_pc=BFC00004, id_inst=24020005.
- cp0_branch_flag=1 while in WAIT for pc BFC00008, data_ok two cycles later with 12345678 -> word discarded, id_valid=0; next fetch at new pc (e.g. BFC00380) delivered normally.
- cpu_rst_n pulsed low while in REQ -> inst_req=0 immediately (asynchronous), id_valid=0, id_pc=BFC00000.
- (FETCH_ADDR_CHECK_EN) pc=BFC00002 -> no inst_req; id_valid=1, id_excp_adel=1, id_inst=00000000.
